adsr_envelope_fsm: RTL and testbench
====================================

// Module: adsr_envelope_fsm
// PURPOSE
//  Single-clock, parametrised ADSR envelope generator and VCA for the synth voice path.
//  Rate dividers are internal and per-stage; no divided clocks are used.
//  Release starts from the level current at note-off. Retrigger during release is legato.
//  Sits between oscillator/mixer output and output DAC/summing stage; one instance per voice.
// PARAMETERS
//  DATA_W  16  width of unsigned input sample
//  LVL_W   8   envelope level width; full scale LMAX = 2**LVL_W-1
//  RATE_W  16  width of per-stage rate (clocks per level step, minus 1)
// PORTS
//  clk            in   1               system clock
//  reset          in   1               synchronous, active-high reset
//  note_on        in   1               gate, level-sensitive; edges detected internally
//  in             in   DATA_W          unsigned sample to be enveloped
//  attack_rate    in   RATE_W          clocks per attack step = attack_rate+1
//  decay_rate     in   RATE_W          clocks per decay step = decay_rate+1
//  release_rate   in   RATE_W          clocks per release step = release_rate+1
//  sustain_level  in   LVL_W           sustain target, 0..LMAX
//  signal_out     out  DATA_W+LVL_W    registered in*env_level
//  env_level      out  LVL_W           current envelope level
//  state_out      out  3               IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//  busy           out  1               high whenever state != IDLE
// BEHAVIOUR
//  Reset:
//   - state=IDLE; env_level=0, signal_out=0, busy=0, rate counter=0, note_on history reg=0.
//   - Reset wins over every other event on the same edge.
//  Edges: gate_rise = note_on & ~note_d; gate_fall = ~note_on & note_d (note_d = note_on delayed 1 clk).
//  Rate tick:
//   - cnt counts 0..rate_sel, where rate_sel is the rate of the current state.
//   - tick=1 on the cycle cnt==rate_sel, then cnt<=0. rate=0 gives a tick every clock.
//   - cnt clears to 0 on every state change. Rates are sampled live; if a lowered rate leaves cnt>rate_sel, tick and clear.
//  Transitions (priority top-down, evaluated each clk):
//   - any state, gate_fall, state!=IDLE -> RELEASE; level held this cycle.
//   - IDLE, gate_rise -> ATTACK; level stays 0.
//   - RELEASE, gate_rise -> ATTACK from the current level (no jump to 0).
//   - ATTACK, tick: level+1. On reaching LMAX -> DECAY on the same edge.
//   - DECAY: if level<=sustain_level -> SUSTAIN, level<=sustain_level; else on tick level-1.
//   - SUSTAIN: level follows sustain_level every clock (live tracking); stays until gate_fall.
//   - RELEASE, tick: level-1. On reaching 0 -> IDLE on the same edge.
//     If already 0 on entry -> IDLE next clk.
//   - gate_rise while in ATTACK/DECAY/SUSTAIN is impossible (gate already high); ignore.
//  Arithmetic:
//   - level never wraps: saturate at LMAX and at 0.
//   - sustain_level=LMAX: DECAY lasts 1 clk. sustain_level=0: the envelope passes through SUSTAIN at level 0.
//  Output:
//   - signal_out <= in*env_level, unsigned full-width product, no truncation.
//   - Registered: 1 clk latency after the env_level change.
//  Mid-operation: note_on is pulsed 1 clk high then low -> ATTACK for 1 clk, then RELEASE from that level.
// TESTING  (LVL_W=4 -> LMAX=15, DATA_W=16 unless noted)
//  1 reset: assert reset during SUSTAIN with level 9 -> next clk state=0, env_level=0, busy=0, signal_out=0.
//  2 full ADSR:
//     stimulus - all rates=0, sustain=6, in=16'h1000, note_on high 40 clks then low.
//     response - level 0..15 in 15 clks; DECAY 15->6 in 9 clks; SUSTAIN holds 6;
//                signal_out=16'h6000 (zero-extended); after note-off, 6 clks to 0, then IDLE, busy=0.
//  3 rate divide: attack_rate=3 -> level increments exactly every 4 clks; 15 steps = 60 clks.
//  4 early release: note_off in ATTACK at level 7 -> RELEASE starts at 7 (not sustain); reaches 0 after 7 ticks.
//  5 legato retrigger: note_on rises in RELEASE at level 4 -> ATTACK resumes from 4; reaches 15 after 11 ticks.
//  6 live sustain + edges:
//     - sustain 6->10 while in SUSTAIN -> env_level=10 next clk.
//     - sustain=15 -> DECAY lasts 1 clk.
//     - sustain=0 -> enters SUSTAIN at level 0.

Source files
------------

// File: rtl/adsr_envelope_fsm.sv
// ADSR envelope generator and VCA for one synth voice: a per-stage rate divider
// steps an LVL_W-bit level, and the output is the registered product in*env_level.
module adsr_envelope_fsm #(
  parameter int DATA_W = 16,
  parameter int LVL_W  = 8,
  parameter int RATE_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     note_on,
  input  logic [DATA_W-1:0]        in,
  input  logic [RATE_W-1:0]        attack_rate,
  input  logic [RATE_W-1:0]        decay_rate,
  input  logic [RATE_W-1:0]        release_rate,
  input  logic [LVL_W-1:0]         sustain_level,
  output logic [DATA_W+LVL_W-1:0]  signal_out,
  output logic [LVL_W-1:0]         env_level,
  output logic [2:0]               state_out,
  output logic                     busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [LVL_W-1:0] LMAX    = '1;
  localparam logic [LVL_W-1:0] LMAX_M1 = LMAX - 1'b1;
  localparam logic [LVL_W-1:0] LVL_ONE = {{(LVL_W-1){1'b0}}, 1'b1};

  logic [2:0]               state_q, state_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic [RATE_W-1:0]        cnt_q, cnt_d;
  logic                     note_d_q;
  logic [DATA_W+LVL_W-1:0]  signal_q, signal_d;

  logic                     gate_rise;
  logic                     gate_fall;
  logic [RATE_W-1:0]        rate_sel;
  logic                     tick;

  assign gate_rise = note_on & ~note_d_q;
  assign gate_fall = ~note_on & note_d_q;

  // NOTE: every variable assigned in an always_comb gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    rate_sel = '0;
    case (state_q)
      S_ATTACK:  rate_sel = attack_rate;
      S_DECAY:   rate_sel = decay_rate;
      S_RELEASE: rate_sel = release_rate;
      default:   rate_sel = '0;
    endcase
  end

  // ">=" rather than "==" so a rate lowered below the running count still ticks.
  assign tick = (cnt_q >= rate_sel);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (gate_fall && (state_q != S_IDLE)) begin
      state_d = S_RELEASE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gate_rise) state_d = S_ATTACK;
        end
        S_ATTACK: begin
          if (level_q == LMAX) begin
            state_d = S_DECAY;
          end else if (tick) begin
            level_d = level_q + 1'b1;
            if (level_q == LMAX_M1) state_d = S_DECAY;
          end
        end
        S_DECAY: begin
          if (level_q <= sustain_level) begin
            state_d = S_SUSTAIN;
            level_d = sustain_level;
          end else if (tick) begin
            level_d = level_q - 1'b1;
          end
        end
        S_SUSTAIN: begin
          level_d = sustain_level;
        end
        S_RELEASE: begin
          if (gate_rise) begin
            state_d = S_ATTACK;
          end else if (level_q == '0) begin
            state_d = S_IDLE;
          end else if (tick) begin
            level_d = level_q - 1'b1;
            if (level_q == LVL_ONE) state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          level_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((state_d != state_q) || tick) cnt_d = '0;
  end

  assign signal_d = in * level_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      cnt_q    <= '0;
      note_d_q <= 1'b0;
      signal_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      note_d_q <= note_on;
      signal_q <= signal_d;
    end
  end

  assign signal_out = signal_q;
  assign env_level  = level_q;
  assign state_out  = state_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope_fsm.sv
// Directed bench for adsr_envelope_fsm with LVL_W=4 (LMAX=15), DATA_W=16.
module tb_adsr_envelope_fsm;

  localparam int DATA_W = 16;
  localparam int LVL_W  = 4;
  localparam int RATE_W = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    note_on;
  logic [DATA_W-1:0]       in;
  logic [RATE_W-1:0]       attack_rate, decay_rate, release_rate;
  logic [LVL_W-1:0]        sustain_level;
  logic [DATA_W+LVL_W-1:0] signal_out;
  logic [LVL_W-1:0]        env_level;
  logic [2:0]              state_out;
  logic                    busy;

  int n_checks = 0;
  int n_fail   = 0;

  adsr_envelope_fsm #(.DATA_W(DATA_W), .LVL_W(LVL_W), .RATE_W(RATE_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .note_on       (note_on),
    .in            (in),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .release_rate  (release_rate),
    .sustain_level (sustain_level),
    .signal_out    (signal_out),
    .env_level     (env_level),
    .state_out     (state_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    note_on = 1'b0;
    step(1);
    reset   = 1'b0;
  endtask

  task automatic chk_sl(input string tag, input logic [2:0] st, input logic [LVL_W-1:0] lvl);
    check({tag, "_state"}, state_out, st);
    check({tag, "_level"}, env_level, lvl);
  endtask

  initial begin
    reset = 1'b1; note_on = 1'b0; in = 16'h1000;
    attack_rate = '0; decay_rate = '0; release_rate = '0; sustain_level = 4'd6;
    step(2);
    reset = 1'b0;
    check("rst_state",  state_out, 3'd0);
    check("rst_level",  env_level, 4'd0);
    check("rst_busy",   busy, 1'b0);
    check("rst_signal", signal_out, 20'h0);

    // Full ADSR with all rates 0, sustain 6
    note_on = 1'b1;
    step(1);  chk_sl("adsr_rise", 3'd1, 4'd0);
    check("adsr_busy", busy, 1'b1);
    step(1);  chk_sl("adsr_att1", 3'd1, 4'd1);
    step(14); chk_sl("adsr_top", 3'd2, 4'd15);
    step(9);  chk_sl("adsr_dec6", 3'd2, 4'd6);
    step(1);  chk_sl("adsr_sus", 3'd3, 4'd6);
    check("adsr_sig6", signal_out, 20'h06000);
    // Live sustain tracking
    sustain_level = 4'd10;
    step(1);  chk_sl("live_sus10", 3'd3, 4'd10);
    check("live_sig_lag", signal_out, 20'h06000);
    step(1);  check("live_sig10", signal_out, 20'h0A000);
    sustain_level = 4'd6;
    step(1);  chk_sl("live_sus6", 3'd3, 4'd6);
    step(10);
    note_on = 1'b0;
    step(1);  chk_sl("rel_entry", 3'd4, 4'd6);
    step(5);  chk_sl("rel_lvl1", 3'd4, 4'd1);
    step(1);  chk_sl("rel_done", 3'd0, 4'd0);
    check("rel_busy", busy, 1'b0);
    step(1);  check("rel_sig0", signal_out, 20'h0);

    // Reset during SUSTAIN at level 9
    do_reset();
    sustain_level = 4'd9;
    note_on = 1'b1;
    step(23); chk_sl("pre_rst_sus9", 3'd3, 4'd9);
    reset = 1'b1;
    step(1);
    check("mid_rst_state", state_out, 3'd0);
    check("mid_rst_level", env_level, 4'd0);
    check("mid_rst_busy",  busy, 1'b0);
    check("mid_rst_sig",   signal_out, 20'h0);
    reset = 1'b0; note_on = 1'b0;
    step(1);  chk_sl("post_rst_idle", 3'd0, 4'd0);

    // Attack divider: attack_rate=3 -> one step per 4 clocks
    attack_rate = 16'd3; sustain_level = 4'd6;
    note_on = 1'b1;
    step(1);  chk_sl("div_rise", 3'd1, 4'd0);
    step(3);  chk_sl("div_hold", 3'd1, 4'd0);
    step(1);  chk_sl("div_first", 3'd1, 4'd1);
    step(55); chk_sl("div_14", 3'd1, 4'd14);
    step(1);  chk_sl("div_15", 3'd2, 4'd15);
    attack_rate = '0;

    // Early release from ATTACK at level 7, release_rate=1
    do_reset();
    release_rate = 16'd1;
    note_on = 1'b1;
    step(1);
    step(7);  chk_sl("early_att7", 3'd1, 4'd7);
    note_on = 1'b0;
    step(1);  chk_sl("early_rel7", 3'd4, 4'd7);
    step(1);  chk_sl("early_hold", 3'd4, 4'd7);
    step(1);  chk_sl("early_rel6", 3'd4, 4'd6);
    step(10); chk_sl("early_rel1", 3'd4, 4'd1);
    step(2);  chk_sl("early_idle", 3'd0, 4'd0);
    release_rate = '0;

    // Legato retrigger from RELEASE at level 4
    do_reset();
    note_on = 1'b1;
    step(26); chk_sl("leg_sus", 3'd3, 4'd6);
    note_on = 1'b0;
    step(1);
    step(2);  chk_sl("leg_rel4", 3'd4, 4'd4);
    note_on = 1'b1;
    step(1);  chk_sl("leg_att4", 3'd1, 4'd4);
    step(10); chk_sl("leg_att14", 3'd1, 4'd14);
    step(1);  chk_sl("leg_top", 3'd2, 4'd15);

    // sustain = LMAX: DECAY for one clock; full-scale product
    do_reset();
    sustain_level = 4'd15; in = 16'hFFFF;
    note_on = 1'b1;
    step(16); chk_sl("s15_dec", 3'd2, 4'd15);
    step(1);  chk_sl("s15_sus", 3'd3, 4'd15);
    step(1);  check("s15_sig", signal_out, 20'hEFFF1);

    // sustain = 0: passes through SUSTAIN at level 0
    do_reset();
    sustain_level = 4'd0; in = 16'h1000;
    note_on = 1'b1;
    step(16); chk_sl("s0_dec", 3'd2, 4'd15);
    step(15); chk_sl("s0_dec0", 3'd2, 4'd0);
    step(1);  chk_sl("s0_sus", 3'd3, 4'd0);
    check("s0_busy", busy, 1'b1);

    // One-clock gate pulse
    do_reset();
    note_on = 1'b1;
    step(1);  chk_sl("pulse_att", 3'd1, 4'd0);
    note_on = 1'b0;
    step(1);  chk_sl("pulse_rel", 3'd4, 4'd0);
    step(1);  chk_sl("pulse_idle", 3'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
